ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 148 ++++++++++++++
 tb/tb_ifetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding bus request feeding a small decode queue.
// Optional IFETCH_ALIGN_CHECK_EN: a misaligned PC yields an address-error entry instead of a bus request.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq,
    output logic [31:0] iaddr,
    input  logic        iaddr_ok,
    input  logic        idata_ok,
    input  logic [31:0] idata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus4,
    output logic        out_adel
);
    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      r_pc;
    logic [31:0]      r_req_pc;
    logic             r_outstanding;
    logic             r_discard;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [31:0]      r_q_instr [QUEUE_DEPTH];
    logic [31:0]      r_q_pc    [QUEUE_DEPTH];

    logic [31:0]      w_aligned_pc;
    logic             w_hold;
    logic [CNT_W-1:0] w_slots;
    logic             w_room;
    logic             w_bus_free;
    logic             w_misaligned;
    logic             w_accept;
    logic             w_push_data;
    logic             w_push_adel;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_push_instr;
    logic [31:0]      w_push_pc;

    assign w_aligned_pc = {r_pc[31:2], 2'b00};
    // A discarded response arriving this cycle frees its slot immediately.
    assign w_hold       = r_outstanding & ~(idata_ok & r_discard);
    assign w_slots      = r_count + CNT_W'(w_hold);
    assign w_room       = (w_slots < CNT_W'(QUEUE_DEPTH));
    assign w_bus_free   = ~r_outstanding | idata_ok;

    assign ireq         = ~reset & ~redirect & w_bus_free & w_room & ~w_misaligned;
    assign iaddr        = w_aligned_pc;
    assign w_accept     = ireq & iaddr_ok;

    assign out_valid    = (r_count != '0);
    assign w_pop        = ~reset & ~redirect & out_valid & out_ready;
    assign w_push_data  = ~reset & ~redirect & idata_ok & r_outstanding & ~r_discard;
    assign w_push       = w_push_data | w_push_adel;
    assign w_push_instr = w_push_adel ? 32'd0 : idata;
    assign w_push_pc    = w_push_adel ? r_pc : r_req_pc;

    assign out_instr    = out_valid ? r_q_instr[r_rd_ptr] : 32'd0;
    assign out_pc       = out_valid ? r_q_pc[r_rd_ptr] : 32'd0;
    assign out_pcplus4  = out_valid ? (r_q_pc[r_rd_ptr] + 32'd4) : 32'd0;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic r_stall;
    logic r_q_adel [QUEUE_DEPTH];

    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign w_push_adel  = ~reset & ~redirect & w_misaligned & ~r_stall & ~w_push_data
                          & (r_count < CNT_W'(QUEUE_DEPTH));
    assign out_adel     = out_valid & r_q_adel[r_rd_ptr];

    // Fetch stays frozen after the error entry until the next redirect.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            r_stall <= 1'b0;
        end else if (w_push_adel) begin
            r_stall <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_adel[r_wr_ptr] <= w_push_adel;
        end
    end
`else
    assign w_misaligned = 1'b0;
    assign w_push_adel  = 1'b0;
    assign out_adel     = 1'b0;
`endif

    // Fetch PC, outstanding/discard tracking and queue pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_req_pc      <= 32'd0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (redirect) begin
            r_pc          <= redirect_pc;
            r_outstanding <= r_outstanding & ~idata_ok;
            r_discard     <= r_outstanding & ~idata_ok;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            if (w_accept) begin
                r_pc     <= r_pc + 32'd4;
                r_req_pc <= w_aligned_pc;
            end
            r_outstanding <= w_accept | (r_outstanding & ~idata_ok);
            if (idata_ok) begin
                r_discard <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Queue storage needs no reset: outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= w_push_instr;
            r_q_pc[r_wr_ptr]    <= w_push_pc;
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: per-cycle vector table plus fill/drain and alignment sequences.
module tb_ifetch_unit;
    localparam logic [31:0] B = 32'hBFC0_0000;

    logic        clk;
    logic        reset;
    logic        ireq;
    logic [31:0] iaddr;
    logic        iaddr_ok;
    logic        idata_ok;
    logic [31:0] idata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic        out_adel;

    ifetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .ireq        (ireq),
        .iaddr       (iaddr),
        .iaddr_ok    (iaddr_ok),
        .idata_ok    (idata_ok),
        .idata       (idata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pcplus4 (out_pcplus4),
        .out_adel    (out_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        aok;
        logic        dok;
        logic [31:0] data;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_ireq;
        logic [31:0] e_iaddr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tv [16];
    int   n_pass;
    int   n_tot;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tot++;
        if (act !== want) begin
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of inputs after the rising edge, return at the falling edge for sampling.
    task automatic drive(input logic rst, input logic aok, input logic dok, input logic [31:0] data,
                         input logic redir, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        reset       = rst;
        iaddr_ok    = aok;
        idata_ok    = dok;
        idata       = data;
        redirect    = redir;
        redirect_pc = rpc;
        out_ready   = rdy;
        @(negedge clk);
    endtask

    logic        pend;
    logic [31:0] pend_addr;
    int          n_acc;
    int          n_pop;

    initial begin
        n_pass = 0;
        n_tot  = 0;
        reset = 1'b1; iaddr_ok = 1'b0; idata_ok = 1'b0; idata = 32'd0;
        redirect = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;

        tv[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, B,          1'b0, 32'h0,         32'h0};
        tv[1]  = '{1'b0, 1'b1, 1'b1, 32'h2408_0001, 1'b0, 32'h0,         1'b0, 1'b1, B+32'h4,    1'b0, 32'h0,         32'h0};
        tv[2]  = '{1'b0, 1'b1, 1'b1, 32'h2408_0002, 1'b0, 32'h0,         1'b1, 1'b1, B+32'h8,    1'b1, 32'h2408_0001, B};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, B+32'h100,     1'b0, 1'b0, 32'h0,      1'b1, 32'h2408_0002, B+32'h4};
        tv[4]  = '{1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 1'b1, B+32'h100,  1'b0, 32'h0,         32'h0};
        tv[5]  = '{1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 32'h0,         1'b0, 1'b1, B+32'h104,  1'b0, 32'h0,         32'h0};
        tv[6]  = '{1'b0, 1'b1, 1'b1, 32'h2222_2222, 1'b1, B+32'h200,     1'b1, 1'b0, 32'h0,      1'b1, 32'h1111_1111, B+32'h100};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, B+32'h200,  1'b0, 32'h0,         32'h0};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 32'h0,         1'b0, 1'b1, B+32'h204,  1'b0, 32'h0,         32'h0};
        tv[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,      1'b1, 32'h3333_3333, B+32'h200};
        tv[10] = '{1'b0, 1'b1, 1'b1, 32'h4444_4444, 1'b0, 32'h0,         1'b0, 1'b1, B,          1'b0, 32'h0,         32'h0};
        tv[11] = '{1'b0, 1'b1, 1'b1, 32'h5555_5555, 1'b0, 32'h0,         1'b0, 1'b1, B+32'h4,    1'b0, 32'h0,         32'h0};
        tv[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0,      1'b1, 32'h5555_5555, B};
        tv[13] = '{1'b0, 1'b0, 1'b1, 32'h6666_6666, 1'b0, 32'h0,         1'b0, 1'b1, B+32'h8,    1'b0, 32'h0,         32'h0};
        tv[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, B+32'h8,    1'b1, 32'h6666_6666, B+32'h4};
        tv[15] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, B+32'h8,    1'b1, 32'h6666_6666, B+32'h4};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ireq",        32'(ireq), 32'd0);
        chk("rst_out_valid",   32'(out_valid), 32'd0);
        chk("rst_out_instr",   out_instr, 32'd0);
        chk("rst_out_pc",      out_pc, 32'd0);
        chk("rst_out_pcplus4", out_pcplus4, 32'd0);
        chk("rst_out_adel",    32'(out_adel), 32'd0);

        // Per-cycle table: basic fetch, redirect with discard, redirect+data+pop, reset mid-flight, stall hold
        for (int i = 0; i < 16; i++) begin
            drive(tv[i].rst, tv[i].aok, tv[i].dok, tv[i].data, tv[i].redir, tv[i].rpc, tv[i].rdy);
            chk($sformatf("v%0d_ireq", i), 32'(ireq), 32'(tv[i].e_ireq));
            if (tv[i].e_ireq) chk($sformatf("v%0d_iaddr", i), iaddr, tv[i].e_iaddr);
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tv[i].e_vld));
            if (tv[i].e_vld) begin
                chk($sformatf("v%0d_out_instr", i), out_instr, tv[i].e_instr);
                chk($sformatf("v%0d_out_pc", i), out_pc, tv[i].e_pc);
                chk($sformatf("v%0d_out_pcplus4", i), out_pcplus4, tv[i].e_pc + 32'd4);
                chk($sformatf("v%0d_out_adel", i), 32'(out_adel), 32'd0);
            end
        end

        // Fill with decode stalled: responder answers one cycle after each accept
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        pend = 1'b0; pend_addr = 32'h0; n_acc = 0;
        for (int c = 0; c < 11; c++) begin
            drive(1'b0, 1'b1, pend, {16'hA000, pend_addr[15:0]}, 1'b0, 32'h0, (c == 10) ? 1'b1 : 1'b0);
            if (c == 10) begin
                chk("fill_accepts", 32'(n_acc), 32'd4);
                chk("fill_ireq_low", 32'(ireq), 32'd0);
                chk("fill_head_pc", out_pc, B);
                chk("fill_head_instr", out_instr, 32'hA000_0000);
            end
            if (ireq && iaddr_ok) begin
                n_acc++;
                pend_addr = iaddr;
                pend = 1'b1;
            end else begin
                pend = 1'b0;
            end
        end
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b1, pend, {16'hA000, pend_addr[15:0]}, 1'b0, 32'h0, 1'b0);
            if (ireq && iaddr_ok) begin
                n_acc++;
                pend_addr = iaddr;
                pend = 1'b1;
            end else begin
                pend = 1'b0;
            end
        end
        chk("refill_accepts", 32'(n_acc), 32'd5);
        chk("refill_addr", pend_addr, B + 32'h10);
        chk("refill_ireq_low", 32'(ireq), 32'd0);
        chk("refill_head_pc", out_pc, B + 32'h4);
        n_pop = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            if (out_valid) begin
                chk($sformatf("drain%0d_pc", n_pop), out_pc, B + 32'h4 + 32'(4 * n_pop));
                chk($sformatf("drain%0d_instr", n_pop), out_instr, 32'hA000_0004 + 32'(4 * n_pop));
                n_pop++;
            end
        end
        chk("drain_count", 32'(n_pop), 32'd4);

        // Redirect to a misaligned target
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, B + 32'h102, 1'b0);
        chk("mis_redir_ireq", 32'(ireq), 32'd0);
`ifdef IFETCH_ALIGN_CHECK_EN
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("mis_ireq0", 32'(ireq), 32'd0);
        chk("mis_valid0", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("mis_ireq1", 32'(ireq), 32'd0);
        chk("mis_valid1", 32'(out_valid), 32'd1);
        chk("mis_adel", 32'(out_adel), 32'd1);
        chk("mis_pc", out_pc, B + 32'h102);
        chk("mis_pcplus4", out_pcplus4, B + 32'h106);
        chk("mis_instr", out_instr, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("mis_stall_ireq", 32'(ireq), 32'd0);
        chk("mis_stall_valid", 32'(out_valid), 32'd0);
`else
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("mis_ireq", 32'(ireq), 32'd1);
        chk("mis_iaddr", iaddr, B + 32'h100);
        drive(1'b0, 1'b0, 1'b1, 32'h7777_7777, 1'b0, 32'h0, 1'b0);
        chk("mis_valid0", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("mis_valid1", 32'(out_valid), 32'd1);
        chk("mis_pc", out_pc, B + 32'h100);
        chk("mis_pcplus4", out_pcplus4, B + 32'h104);
        chk("mis_instr", out_instr, 32'h7777_7777);
        chk("mis_adel", 32'(out_adel), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
